// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the mem_slave memory target.
//   - default widths for address, data and access counters
//   - convenience typedefs for the default configuration
//   - control FSM state encoding for the read-response pipe
//   - storage word width, which grows by one parity bit when the build
//     defines MEM_PARITY_EN
// ---------------------------------------------------------------------------
package mem_pkg;

   localparam int DEFAULT_ADDR_W = 2;
   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_CNT_W  = 8;

   typedef logic [DEFAULT_ADDR_W-1:0] addr_t;
   typedef logic [DEFAULT_DATA_W-1:0] data_t;
   typedef logic [DEFAULT_CNT_W-1:0]  cnt_t;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } ctl_state_e;

`ifdef MEM_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

endpackage : mem_pkg

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// DEPTH x WORD_W register-based storage with one write port and one
// registered read port. A read and a write in the same cycle to the same
// word return the old contents (read-before-write). Every word is forced to
// RESET_WORD on reset and the read register is cleared to zero.
//
// Ports
//   clk       in   clock, all state on posedge
//   rst       in   asynchronous active-high reset
//   wrEn_i    in   write strobe
//   wrAddr_i  in   write word address
//   wrData_i  in   write word
//   rdEn_i    in   read strobe
//   rdAddr_i  in   read word address
//   rdData_o  out  registered read word, holds until the next read
// ---------------------------------------------------------------------------
module mem_array #(
   parameter int                ADDR_W     = 2,
   parameter int                WORD_W     = 8,
   parameter logic [WORD_W-1:0] RESET_WORD = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrEn_i,
   input  logic [ADDR_W-1:0] wrAddr_i,
   input  logic [WORD_W-1:0] wrData_i,
   input  logic              rdEn_i,
   input  logic [ADDR_W-1:0] rdAddr_i,
   output logic [WORD_W-1:0] rdData_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdData_q;

   // Storage and read register. Both updates are non-blocking, so a read of
   // the word being written in the same cycle naturally sees the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= RESET_WORD;
         end
         rdData_q <= '0;
      end else begin
         if (rdEn_i) begin
            rdData_q <= mem_q[rdAddr_i];
         end
         if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
         end
      end
   end

   assign rdData_o = rdData_q;

endmodule : mem_array

// File: rtl/mem_slave.sv
// ---------------------------------------------------------------------------
// mem_slave
// Synchronous memory target on the memory bus. Writes land on the clock edge
// that samples wr_en; reads return one cycle after the edge that samples
// rd_en. Tracks which words have been written since reset, counts accepted
// reads and writes with saturating counters, and optionally stores and
// checks a per-word even-parity bit.
//
// Optional feature macro: MEM_PARITY_EN
//   defined   -> parity bit stored per word, inj_err / par_err ports present
//   undefined -> no parity storage, inj_err / par_err ports absent
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   addr       in   word address for both read and write
//   wr_en      in   write strobe
//   rd_en      in   read strobe
//   wdata      in   write data
//   inj_err    in   (MEM_PARITY_EN) store inverted parity with this write
//   rdata      out  registered read data, holds until the next read
//   rd_valid   out  one-cycle pulse per read
//   rd_uninit  out  with rd_valid: word had not been written since reset
//   wr_cnt     out  accepted writes, saturating
//   rd_cnt     out  accepted reads, saturating
//   par_err    out  (MEM_PARITY_EN) with rd_valid: stored parity mismatch
// ---------------------------------------------------------------------------
import mem_pkg::*;

module mem_slave #(
   parameter int                ADDR_W    = DEFAULT_ADDR_W,
   parameter int                DATA_W    = DEFAULT_DATA_W,
   parameter int                CNT_W     = DEFAULT_CNT_W,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] wdata,
`ifdef MEM_PARITY_EN
   input  logic              inj_err,
`endif
   output logic [DATA_W-1:0] rdata,
   output logic              rd_valid,
   output logic              rd_uninit,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  rd_cnt
`ifdef MEM_PARITY_EN
   ,
   output logic              par_err
`endif
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam int              WORD_W  = DATA_W + PAR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef MEM_PARITY_EN
   localparam logic [WORD_W-1:0] RESET_WORD = {^RESET_VAL, RESET_VAL};
`else
   localparam logic [WORD_W-1:0] RESET_WORD = RESET_VAL;
`endif

   ctl_state_e        state_q, state_d;
   logic [DEPTH-1:0]  written_q, written_d;
   logic [CNT_W-1:0]  wrCnt_q, wrCnt_d;
   logic [CNT_W-1:0]  rdCnt_q, rdCnt_d;
   logic              rdUninit_q, rdUninit_d;
   logic [WORD_W-1:0] wrWord;
   logic [WORD_W-1:0] rdWord;

   // Build the stored word. With parity enabled the top bit is the even
   // parity of the data, optionally inverted to model a corrupted store.
`ifdef MEM_PARITY_EN
   assign wrWord = {(^wdata) ^ inj_err, wdata};
`else
   assign wrWord = wdata;
`endif

   mem_array #(
      .ADDR_W     (ADDR_W),
      .WORD_W     (WORD_W),
      .RESET_WORD (RESET_WORD)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .wrEn_i   (wr_en),
      .wrAddr_i (addr),
      .wrData_i (wrWord),
      .rdEn_i   (rd_en),
      .rdAddr_i (addr),
      .rdData_o (rdWord)
   );

   // Response pipe: stay in RESP as long as reads keep arriving so that
   // back-to-back reads hold rd_valid high continuously.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rd_en) state_d = RESP;
         RESP:    state_d = rd_en ? RESP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bookkeeping next-state: written bitmap, saturating counters, and the
   // uninitialised flag captured from the bitmap before this cycle's write.
   always_comb begin
      written_d  = written_q;
      wrCnt_d    = wrCnt_q;
      rdCnt_d    = rdCnt_q;
      rdUninit_d = 1'b0;
      if (wr_en) begin
         written_d[addr] = 1'b1;
         if (wrCnt_q != CNT_MAX) begin
            wrCnt_d = wrCnt_q + 1'b1;
         end
      end
      if (rd_en) begin
         rdUninit_d = ~written_q[addr];
         if (rdCnt_q != CNT_MAX) begin
            rdCnt_d = rdCnt_q + 1'b1;
         end
      end
   end

   // State registers; reset discards any in-flight read response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         written_q  <= '0;
         wrCnt_q    <= '0;
         rdCnt_q    <= '0;
         rdUninit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         written_q  <= written_d;
         wrCnt_q    <= wrCnt_d;
         rdCnt_q    <= rdCnt_d;
         rdUninit_q <= rdUninit_d;
      end
   end

   assign rd_valid  = (state_q == RESP);
   assign rd_uninit = rd_valid & rdUninit_q;
   assign rdata     = rdWord[DATA_W-1:0];
   assign wr_cnt    = wrCnt_q;
   assign rd_cnt    = rdCnt_q;

   // Parity check of the word returned by the last read, only reported
   // while that read is being presented.
`ifdef MEM_PARITY_EN
   assign par_err = rd_valid & (rdWord[DATA_W] != (^rdWord[DATA_W-1:0]));
`endif

endmodule : mem_slave

// File: tb/tb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_mem_slave
// Self-checking bench for mem_slave. A behavioural model of the memory
// (arrays plus integer counters) tracks what every output must be; a
// compare process checks the DUT against it on every falling edge, and the
// directed sequence adds literal expectations for known scenarios.
// Parity scenarios are included when MEM_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_slave;
   import mem_pkg::*;

   localparam int CNT_MAX = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] addr = '0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] wdata = '0;
   logic       inj_err = 1'b0;
   logic [7:0] rdata;
   logic       rd_valid;
   logic       rd_uninit;
   logic [7:0] wr_cnt;
   logic [7:0] rd_cnt;
   logic       par_err;

   int  testsRun = 0;
   int  testsFailed = 0;
   bit  checkEn = 1'b0;

   // Behavioural model state
   logic [7:0] modelMem [4];
   bit         modelWritten [4];
   bit         modelPar [4];
   int         modelWrCnt;
   int         modelRdCnt;
   logic [7:0] expRdata;
   bit         expValid;
   bit         expUninit;
   bit         expPar;

   always #5 clk = ~clk;

   mem_slave dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .wdata     (wdata),
`ifdef MEM_PARITY_EN
      .inj_err   (inj_err),
`endif
      .rdata     (rdata),
      .rd_valid  (rd_valid),
      .rd_uninit (rd_uninit),
      .wr_cnt    (wr_cnt),
      .rd_cnt    (rd_cnt)
`ifdef MEM_PARITY_EN
      ,
      .par_err   (par_err)
`endif
   );

`ifndef MEM_PARITY_EN
   assign par_err = 1'b0;
`endif

   // Compare one observed value against its required value.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one bus cycle at a falling edge; it is sampled on the next rising
   // edge and the task returns at the following falling edge.
   task automatic applyStimulus(input logic [1:0] a, input logic we, input logic re,
                                input logic [7:0] wd, input logic inj);
      addr    = a;
      wr_en   = we;
      rd_en   = re;
      wdata   = wd;
      inj_err = inj;
      @(negedge clk);
   endtask

   task automatic idleCycle();
      applyStimulus(2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   // Reference model: reads see the memory before this cycle's write.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            modelMem[i]     = 8'h00;
            modelWritten[i] = 1'b0;
            modelPar[i]     = 1'b0;
         end
         modelWrCnt = 0;
         modelRdCnt = 0;
         expRdata   = 8'h00;
         expValid   = 1'b0;
         expUninit  = 1'b0;
         expPar     = 1'b0;
      end else begin
         if (rd_en) begin
            expRdata  = modelMem[addr];
            expValid  = 1'b1;
            expUninit = !modelWritten[addr];
            expPar    = modelPar[addr] != (^modelMem[addr]);
            if (modelRdCnt < CNT_MAX) modelRdCnt++;
         end else begin
            expValid = 1'b0;
         end
         if (wr_en) begin
            modelMem[addr]     = wdata;
            modelWritten[addr] = 1'b1;
            modelPar[addr]     = (^wdata) ^ inj_err;
            if (modelWrCnt < CNT_MAX) modelWrCnt++;
         end
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("rd_valid", 32'(rd_valid), 32'(expValid));
         checkOutput("rdata", 32'(rdata), 32'(expRdata));
         checkOutput("rd_uninit", 32'(rd_uninit), 32'(expValid & expUninit));
         checkOutput("wr_cnt", 32'(wr_cnt), 32'(modelWrCnt));
         checkOutput("rd_cnt", 32'(rd_cnt), 32'(modelRdCnt));
`ifdef MEM_PARITY_EN
         checkOutput("par_err", 32'(par_err), 32'(expValid & expPar));
`endif
      end
   end

   initial begin
      logic [7:0] b2bExp [4];
      b2bExp[0] = 8'h00;
      b2bExp[1] = 8'hA5;
      b2bExp[2] = 8'hC3;
      b2bExp[3] = 8'h00;

      #2 rst = 1'b1;
      checkEn = 1'b1;
      @(negedge clk);
      checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("reset rdata", 32'(rdata), 32'h00);
      checkOutput("reset wr_cnt", 32'(wr_cnt), 32'd0);
      checkOutput("reset rd_cnt", 32'(rd_cnt), 32'd0);
      rst = 1'b0;
      idleCycle();

      // Reads of never-written words
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'(i), 1'b0, 1'b1, 8'h00, 1'b0);
         checkOutput("init read valid", 32'(rd_valid), 32'd1);
         checkOutput("init read data", 32'(rdata), 32'h00);
         checkOutput("init read uninit", 32'(rd_uninit), 32'd1);
      end
      idleCycle();
      checkOutput("valid drops", 32'(rd_valid), 32'd0);
      checkOutput("rdata holds", 32'(rdata), 32'h00);
      checkOutput("rd_cnt after 4", 32'(rd_cnt), 32'd4);

      // Write then read
      applyStimulus(2'd1, 1'b1, 1'b0, 8'hA5, 1'b0);
      applyStimulus(2'd1, 1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput("A5 data", 32'(rdata), 32'hA5);
      checkOutput("A5 uninit", 32'(rd_uninit), 32'd0);
      checkOutput("A5 wr_cnt", 32'(wr_cnt), 32'd1);

      // Read-before-write on the same word
      applyStimulus(2'd2, 1'b1, 1'b0, 8'h3C, 1'b0);
      applyStimulus(2'd2, 1'b1, 1'b1, 8'hC3, 1'b0);
      checkOutput("rbw old data", 32'(rdata), 32'h3C);
      checkOutput("rbw uninit", 32'(rd_uninit), 32'd0);
      applyStimulus(2'd2, 1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput("rbw new data", 32'(rdata), 32'hC3);
      checkOutput("rbw wr_cnt", 32'(wr_cnt), 32'd3);

      // Back-to-back reads
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'(i), 1'b0, 1'b1, 8'h00, 1'b0);
         checkOutput("b2b valid", 32'(rd_valid), 32'd1);
         checkOutput("b2b data", 32'(rdata), 32'(b2bExp[i]));
      end
      idleCycle();
      checkOutput("b2b rd_cnt", 32'(rd_cnt), 32'd11);

      // Write counter saturation
      for (int i = 0; i < 300; i++) begin
         applyStimulus(2'(i % 4), 1'b1, 1'b0, 8'($urandom), 1'b0);
      end
      idleCycle();
      checkOutput("wr_cnt saturated", 32'(wr_cnt), 32'hFF);

      // Reset while a read response is in flight
      addr  = 2'd1;
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b1;
      rd_en = 1'b0;
      #1;
      checkOutput("midrst rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("midrst rdata", 32'(rdata), 32'h00);
      checkOutput("midrst wr_cnt", 32'(wr_cnt), 32'd0);
      checkOutput("midrst rd_cnt", 32'(rd_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(2'd1, 1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput("post rst data", 32'(rdata), 32'h00);
      checkOutput("post rst uninit", 32'(rd_uninit), 32'd1);

`ifdef MEM_PARITY_EN
      // Parity error injection and recovery
      applyStimulus(2'd3, 1'b1, 1'b0, 8'h0F, 1'b1);
      applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput("inj data", 32'(rdata), 32'h0F);
      checkOutput("inj par_err", 32'(par_err), 32'd1);
      applyStimulus(2'd3, 1'b1, 1'b0, 8'h0F, 1'b0);
      applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput("clean par_err", 32'(par_err), 32'd0);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus(2'($urandom_range(3)), 1'($urandom_range(1)),
                       1'($urandom_range(1)), 8'($urandom),
                       1'($urandom_range(7) == 0));
      end
      idleCycle();
      idleCycle();

      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule : tb_mem_slave
